// File: rtl/llr_burst_mem_if.sv
// Bus bundle for llr_burst_mem: lane-word write port, burst request handshake
// and the back-pressured beat stream. The design side uses the slave modport.
interface llr_burst_mem_if #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_DEPTH = 64,
  parameter int NUM_LANE  = 4,
  parameter int MEM_ADDRW = $clog2(MEM_DEPTH),
  parameter int LANE_W    = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1
);
  logic                          i_wen;
  logic [MEM_ADDRW-1:0]          i_waddr;
  logic [LANE_W-1:0]             i_wlane;
  logic [MEM_WIDTH-1:0]          i_wdata;
  logic                          i_req_valid;
  logic                          o_req_ready;
  logic [MEM_ADDRW-1:0]          i_req_addr;
  logic [MEM_ADDRW-1:0]          i_req_len;
  logic                          o_rvalid;
  logic                          i_rready;
  logic [NUM_LANE*MEM_WIDTH-1:0] o_rdata;
  logic                          o_rlast;
  logic                          o_busy;

  modport slave (
    input  i_wen, i_waddr, i_wlane, i_wdata,
    input  i_req_valid, i_req_addr, i_req_len, i_rready,
    output o_req_ready, o_rvalid, o_rdata, o_rlast, o_busy
  );

  modport master (
    output i_wen, i_waddr, i_wlane, i_wdata,
    output i_req_valid, i_req_addr, i_req_len, i_rready,
    input  o_req_ready, o_rvalid, o_rdata, o_rlast, o_busy
  );
endinterface

// File: rtl/llr_burst_mem.sv
// Multi-lane LLR store: per-lane word writes, burst reads that gather all lanes
// at one address per beat into a registered, back-pressured output stream.
module llr_burst_mem #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_DEPTH = 64,
  parameter int NUM_LANE  = 4,
  parameter int MEM_ADDRW = $clog2(MEM_DEPTH),
  parameter int LANE_W    = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  llr_burst_mem_if.slave   bus_if
);

  localparam int                  BEAT_W   = NUM_LANE * MEM_WIDTH;
  localparam logic [LANE_W:0]     LANE_CNT = NUM_LANE[LANE_W:0];
  localparam logic [MEM_ADDRW-1:0] ADDR_ONE = {{(MEM_ADDRW-1){1'b0}}, 1'b1};
  localparam logic [MEM_ADDRW-1:0] ADDR_ZERO = {MEM_ADDRW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  logic [MEM_WIDTH-1:0] mem_q [NUM_LANE][MEM_DEPTH];

  state_t               state_q,  state_d;
  logic [MEM_ADDRW-1:0] ptr_q,    ptr_d;
  logic [MEM_ADDRW-1:0] cnt_q,    cnt_d;
  logic                 rvalid_q, rvalid_d;
  logic                 rlast_q,  rlast_d;
  logic [BEAT_W-1:0]    rdata_q,  rdata_d;
  logic [BEAT_W-1:0]    lane_gather_s;
  logic                 wlane_ok_s;

  assign wlane_ok_s = ({1'b0, bus_if.i_wlane} < LANE_CNT);

  // Lane-word write port; storage is deliberately left out of reset so a
  // loaded pattern survives i_rst_n. Non-blocking update gives read-before-write.
  always_ff @(posedge i_clk) begin
    if (bus_if.i_wen && wlane_ok_s) begin
      mem_q[bus_if.i_wlane][bus_if.i_waddr] <= bus_if.i_wdata;
    end
  end

  // Gather every lane at the current pointer into one beat.
  always_comb begin
    lane_gather_s = {BEAT_W{1'b0}};
    for (int k = 0; k < NUM_LANE; k++) begin
      lane_gather_s[k*MEM_WIDTH +: MEM_WIDTH] = mem_q[k][ptr_q];
    end
  end

  // Read FSM next-state and output-register next values.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_if.i_req_valid) begin
          ptr_d   = bus_if.i_req_addr;
          cnt_d   = bus_if.i_req_len;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // Fetch only when the output slot is empty or draining this cycle.
        if (!rvalid_q || bus_if.i_rready) begin
          rdata_d  = lane_gather_s;
          rvalid_d = 1'b1;
          ptr_d    = ptr_q + ADDR_ONE;
          if (cnt_q == ADDR_ZERO) begin
            cnt_d   = ADDR_ZERO;
            rlast_d = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            cnt_d   = cnt_q - ADDR_ONE;
            rlast_d = 1'b0;
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (bus_if.i_rready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_DRAIN;
        end
      end
      default: begin
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State, pointer, counter and output register; reset aborts any burst.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= ADDR_ZERO;
      cnt_q    <= ADDR_ZERO;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= {BEAT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus_if.o_req_ready = (state_q == ST_IDLE);
  assign bus_if.o_busy      = (state_q != ST_IDLE);
  assign bus_if.o_rvalid    = rvalid_q;
  assign bus_if.o_rlast     = rlast_q;
  assign bus_if.o_rdata     = rdata_q;

endmodule

// File: tb/tb_llr_burst_mem.sv
// Directed bench for llr_burst_mem: a shadow memory supplies expected beats.
module tb_llr_burst_mem;

  logic i_clk;
  logic i_rst_n;
  int   n_checks;
  int   n_fail;
  int   cyc;
  logic [31:0] mdl [4][64];

  llr_burst_mem_if bus ();

  llr_burst_mem dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus_if  (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [127:0] exp_beat(input logic [5:0] a);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = mdl[k][a];
    return r;
  endfunction

  task automatic wr(input logic [1:0] lane, input logic [5:0] addr, input logic [31:0] data);
    bus.i_wen   = 1'b1;
    bus.i_wlane = lane;
    bus.i_waddr = addr;
    bus.i_wdata = data;
    tick();
    bus.i_wen   = 1'b0;
    mdl[lane][addr] = data;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ready"}, {127'd0, bus.o_req_ready}, 128'd1);
    check_eq({tag, "_busy"},  {127'd0, bus.o_busy},      128'd0);
    check_eq({tag, "_rvalid"},{127'd0, bus.o_rvalid},    128'd0);
    check_eq({tag, "_rlast"}, {127'd0, bus.o_rlast},     128'd0);
  endtask

  // Issue a burst, drive rready from pat, check every visible beat against the model.
  task automatic run_burst(input string tag, input logic [5:0] addr, input logic [5:0] len,
                           input logic [15:0] pat, input bit noisy, output int cycles);
    int idx;
    bit hs;
    idx = 0;
    cycles = 0;
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = addr;
    bus.i_req_len   = len;
    tick();
    bus.i_req_valid = 1'b0;
    check_eq({tag, "_acc_busy"},  {127'd0, bus.o_busy},      128'd1);
    check_eq({tag, "_acc_ready"}, {127'd0, bus.o_req_ready}, 128'd0);
    while (idx <= int'(len) && cycles < 400) begin
      bus.i_rready    = pat[cycles % 16];
      bus.i_req_valid = noisy;
      bus.i_req_addr  = 6'(cycles * 7 + 3);
      bus.i_req_len   = 6'd1;
      check_eq({tag, "_busy"}, {127'd0, bus.o_busy}, 128'd1);
      if (bus.o_rvalid) begin
        check_eq({tag, "_rdata"}, bus.o_rdata, exp_beat(6'(int'(addr) + idx)));
        check_eq({tag, "_rlast"}, {127'd0, bus.o_rlast}, {127'd0, (idx == int'(len))});
      end
      hs = bus.o_rvalid && bus.i_rready;
      tick();
      cycles++;
      if (hs) idx++;
    end
    bus.i_req_valid = 1'b0;
    bus.i_rready    = 1'b0;
    check_eq({tag, "_beats"}, 128'(idx), 128'(int'(len) + 1));
    check_idle({tag, "_end"});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    i_rst_n  = 1'b0;
    bus.i_wen = 1'b0;  bus.i_wlane = 2'd0; bus.i_waddr = 6'd0; bus.i_wdata = 32'd0;
    bus.i_req_valid = 1'b0; bus.i_req_addr = 6'd0; bus.i_req_len = 6'd0;
    bus.i_rready = 1'b0;
    for (int k = 0; k < 4; k++) for (int a = 0; a < 64; a++) mdl[k][a] = 32'd0;
    tick(); tick();
    check_idle("rst");
    check_eq("rst_rdata", bus.o_rdata, 128'd0);
    i_rst_n = 1'b1;
    tick();

    // Load and single beat, with explicit latency checks.
    wr(2'd0, 6'd5, 32'h11); wr(2'd1, 6'd5, 32'h22);
    wr(2'd2, 6'd5, 32'h33); wr(2'd3, 6'd5, 32'h44);
    bus.i_req_valid = 1'b1; bus.i_req_addr = 6'd5; bus.i_req_len = 6'd0;
    tick();
    bus.i_req_valid = 1'b0;
    check_eq("t1_busy_n",   {127'd0, bus.o_busy},      128'd1);
    check_eq("t1_ready_n",  {127'd0, bus.o_req_ready}, 128'd0);
    check_eq("t1_rvalid_n", {127'd0, bus.o_rvalid},    128'd0);
    tick();
    check_eq("t1_rvalid", {127'd0, bus.o_rvalid}, 128'd1);
    check_eq("t1_rdata",  bus.o_rdata, 128'h00000044_00000033_00000022_00000011);
    check_eq("t1_rlast",  {127'd0, bus.o_rlast},  128'd1);
    tick();
    check_eq("t1_hold", bus.o_rdata, 128'h00000044_00000033_00000022_00000011);
    bus.i_rready = 1'b1;
    tick();
    bus.i_rready = 1'b0;
    check_idle("t1_done");

    // Preload mem[k][a] = a*4+k.
    for (int a = 0; a < 64; a++) for (int k = 0; k < 4; k++) wr(2'(k), 6'(a), 32'(a*4 + k));

    run_burst("t2", 6'd62, 6'd3, 16'hFFFF, 1'b0, cyc);
    check_eq("t2_cycles", 128'(cyc), 128'd5);

    run_burst("t3", 6'd62, 6'd3, 16'hA5A9, 1'b1, cyc);

    // Collision: write lane0/addr0 on the very edge that fetches address 0.
    wr(2'd0, 6'd0, 32'h5555);
    bus.i_req_valid = 1'b1; bus.i_req_addr = 6'd0; bus.i_req_len = 6'd0;
    tick();
    bus.i_req_valid = 1'b0;
    bus.i_wen = 1'b1; bus.i_wlane = 2'd0; bus.i_waddr = 6'd0; bus.i_wdata = 32'hAA;
    tick();
    bus.i_wen = 1'b0;
    check_eq("t4_old", bus.o_rdata, {32'd3, 32'd2, 32'd1, 32'h5555});
    mdl[0][0] = 32'hAA;
    bus.i_rready = 1'b1;
    tick();
    bus.i_rready = 1'b0;
    run_burst("t4_reread", 6'd0, 6'd0, 16'hFFFF, 1'b0, cyc);

    // Reset mid-burst after three accepted beats.
    bus.i_rready = 1'b1;
    bus.i_req_valid = 1'b1; bus.i_req_addr = 6'd10; bus.i_req_len = 6'd15;
    tick();
    bus.i_req_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      tick();
      check_eq("t5_beat", bus.o_rdata, exp_beat(6'(10 + b)));
    end
    tick();
    i_rst_n = 1'b0;
    #1;
    check_idle("t5_rst");
    check_eq("t5_rst_rdata", bus.o_rdata, 128'd0);
    bus.i_rready = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
    check_idle("t5_post");
    run_burst("t5_after", 6'd20, 6'd2, 16'hFFFF, 1'b0, cyc);

    run_burst("t6_max", 6'd0, 6'd63, 16'hFFFF, 1'b0, cyc);
    check_eq("t6_cycles", 128'(cyc), 128'd65);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
